invader_march_ctl: RTL and testbench
====================================

// Module: invader_march_ctl
// PURPOSE
//  Frame-synchronous position sequencer for the invader formation sprite.
//  Drives the xpos/ypos/enabled inputs of the formation's rectangle renderer.
//  Marches the formation left/right, steps it down at each screen edge and flags landing.
//  Updates only on the vblank rising edge, so coordinates never change mid-frame (no tearing).
// PARAMETERS
//  X_START 32 | Y_START 64 : formation top-left after reset/restart (px)
//  X_MIN 16 | X_MAX 784 : horizontal travel limits (left edge, right edge exclusive bound)
//  GRID_W 352 | GRID_H 160 : formation bounding box size (px)
//  STEP_X 8 | STEP_Y 16 : horizontal step, vertical drop per reversal (px)
//  Y_LIMIT 520 : bottom bound; formation bottom may not exceed it
//  FRAMES_PER_STEP 32 : frames between steps at speed_level 0
//  SPEED_DEC 2 : frames removed from period per speed_level unit
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous, active-high reset
//  vblnk        in   1   vertical blank from timing chain; rising edge = frame tick
//  game_run     in   1   1 = march, 0 = pause (state/positions/counter held)
//  restart      in   1   1-cycle pulse: reload start position, enter MARCH_R
//  speed_level  in   4   speed-up index (e.g. from invaders-killed count)
//  xpos         out  12  formation left x, to renderer
//  ypos         out  12  formation top y, to renderer
//  enabled      out  1   renderer enable
//  anim_frame   out  1   sprite animation phase, toggles every step
//  step_pulse   out  1   1-cycle strobe on every step (sound/logic hook)
//  landed       out  1   sticky: formation reached Y_LIMIT
// BEHAVIOUR
//  Reset: state IDLE, xpos=X_START, ypos=Y_START, enabled=0, anim_frame=0,
//   step_pulse=0, landed=0, frame counter=0, vblnk edge register=0.
//  tick = vblnk & ~vblnk_q (registered); vblnk held high counts once.
//  period = max(1, FRAMES_PER_STEP - SPEED_DEC*speed_level), computed signed, no wrap.
//  States: IDLE, MARCH_R, MARCH_L, LANDED.
//   IDLE: enabled=0; on tick with game_run=1 -> MARCH_R, enabled=1, counter=0.
//   MARCH_R/MARCH_L: on tick with game_run=1, counter++; when counter==period-1 ->
//    counter=0 and a step occurs in the same cycle. Counter >= period (after speed
//    change) also steps immediately.
//   Step in MARCH_R: if xpos+STEP_X+GRID_W > X_MAX -> reversal; else xpos+=STEP_X.
//   Step in MARCH_L: if xpos-STEP_X < X_MIN (signed compare) -> reversal; else xpos-=STEP_X.
//   Reversal: if ypos+STEP_Y+GRID_H > Y_LIMIT -> LANDED, landed=1, no movement;
//    else ypos+=STEP_Y, x unchanged, direction flips.
//   Every step (incl. reversal and landing): anim_frame toggles, step_pulse=1 for 1 cycle.
//   LANDED: positions frozen, enabled=1, landed held until restart/rst.
//  Outputs registered; xpos/ypos change exactly 1 clk after the tick cycle.
//  game_run=0: ticks ignored, everything held; resume continues the count.
//  restart (any state, priority over tick in the same cycle): xpos=X_START,
//   ypos=Y_START, counter=0, landed=0, anim_frame=0, state=MARCH_R, enabled=1.
//  rst has priority over restart.
// TESTING
//  1. speed 0, FRAMES_PER_STEP=4, game_run=1: first tick -> MARCH_R; xpos 32->40 after 4 more ticks, step_pulse 1 cycle.
//  2. Defaults, run 50 steps -> xpos=432; 51st step -> xpos 432, ypos 80, MARCH_L; 52nd -> xpos 424.
//  3. From 432 in MARCH_L: 52 steps -> xpos 16; 53rd -> ypos +16, MARCH_R.
//  4. ypos forced to 352 via run: reversal step -> landed=1, state LANDED, positions frozen on later ticks.
//  5. speed_level=15, FRAMES_PER_STEP=32 -> period clamps to 2; vblnk held high 10 clk counts once.
//  6. game_run=0 for 8 frames -> no change; restart mid-march -> xpos 32, ypos 64, landed 0; rst mid-step -> full reset values.

Source files
------------

// File: rtl/invader_march_ctl.sv
// Invader formation position sequencer: marches the formation left/right on
// vblank ticks, drops it one row at each screen edge and flags landing.
module invader_march_ctl #(
  parameter int X_START         = 32,
  parameter int Y_START         = 64,
  parameter int X_MIN           = 16,
  parameter int X_MAX           = 784,
  parameter int GRID_W          = 352,
  parameter int GRID_H          = 160,
  parameter int STEP_X          = 8,
  parameter int STEP_Y          = 16,
  parameter int Y_LIMIT         = 520,
  parameter int FRAMES_PER_STEP = 32,
  parameter int SPEED_DEC       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        game_run,
  input  logic        restart,
  input  logic [3:0]  speed_level,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        enabled,
  output logic        anim_frame,
  output logic        step_pulse,
  output logic        landed
);

  typedef enum logic [1:0] {IDLE, MARCH_R, MARCH_L, LANDED} state_t;

  state_t             state, state_nx;
  logic               vblnk_q, tick;
  logic [15:0]        cnt, cnt_nx;
  logic [11:0]        xpos_nx, ypos_nx;
  logic               enabled_nx, anim_nx, pulse_nx, landed_nx;
  logic signed [16:0] period;
  logic signed [13:0] xs, ys;
  logic               step_due, right_hit, left_hit, floor_hit, edge_hit;

  // Frames per step, clamped at 1 so a high speed level never wraps negative.
  function automatic logic signed [16:0] calc_period(input logic [3:0] lvl);
    logic signed [16:0] p;
    p = 17'(FRAMES_PER_STEP) - 17'(SPEED_DEC) * $signed({13'd0, lvl});
    if (p < 17'sd1) p = 17'sd1;
    return p;
  endfunction

  assign tick      = vblnk & ~vblnk_q;
  assign period    = calc_period(speed_level);
  assign step_due  = $signed({1'b0, cnt}) >= (period - 17'sd1);
  assign xs        = $signed({2'b00, xpos});
  assign ys        = $signed({2'b00, ypos});
  assign right_hit = (xs + 14'(STEP_X + GRID_W)) > 14'(X_MAX);
  assign left_hit  = (xs - 14'(STEP_X)) < 14'(X_MIN);
  assign floor_hit = (ys + 14'(STEP_Y + GRID_H)) > 14'(Y_LIMIT);
  assign edge_hit  = (state == MARCH_R) ? right_hit : left_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vblnk_q    <= 1'b0;
      cnt        <= '0;
      xpos       <= 12'(X_START);
      ypos       <= 12'(Y_START);
      enabled    <= 1'b0;
      anim_frame <= 1'b0;
      step_pulse <= 1'b0;
      landed     <= 1'b0;
    end else begin
      state      <= state_nx;
      vblnk_q    <= vblnk;
      cnt        <= cnt_nx;
      xpos       <= xpos_nx;
      ypos       <= ypos_nx;
      enabled    <= enabled_nx;
      anim_frame <= anim_nx;
      step_pulse <= pulse_nx;
      landed     <= landed_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    xpos_nx    = xpos;
    ypos_nx    = ypos;
    enabled_nx = enabled;
    anim_nx    = anim_frame;
    pulse_nx   = 1'b0;
    landed_nx  = landed;
    // Restart wins over a coincident tick; that tick is simply consumed.
    if (restart) begin
      state_nx   = MARCH_R;
      cnt_nx     = '0;
      xpos_nx    = 12'(X_START);
      ypos_nx    = 12'(Y_START);
      enabled_nx = 1'b1;
      anim_nx    = 1'b0;
      landed_nx  = 1'b0;
    end else if (tick && game_run) begin
      case (state)
        IDLE: begin
          state_nx   = MARCH_R;
          enabled_nx = 1'b1;
          cnt_nx     = '0;
        end
        MARCH_R, MARCH_L: begin
          if (!step_due) begin
            cnt_nx = cnt + 16'd1;
          end else begin
            cnt_nx   = '0;
            anim_nx  = ~anim_frame;
            pulse_nx = 1'b1;
            if (edge_hit) begin
              if (floor_hit) begin
                state_nx  = LANDED;
                landed_nx = 1'b1;
              end else begin
                ypos_nx  = ypos + 12'(STEP_Y);
                state_nx = (state == MARCH_R) ? MARCH_L : MARCH_R;
              end
            end else if (state == MARCH_R) begin
              xpos_nx = xpos + 12'(STEP_X);
            end else begin
              xpos_nx = xpos - 12'(STEP_X);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_invader_march_ctl.sv
// Randomized bench for invader_march_ctl: a frame-level reference model predicts
// every step into a scoreboard that a monitor drains on each step_pulse.
module tb_invader_march_ctl;

  logic        clk = 1'b0;
  logic        rst, vblnk, game_run, restart;
  logic [3:0]  speed_level;
  logic [11:0] xpos, ypos;
  logic        enabled, anim_frame, step_pulse, landed;

  invader_march_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .game_run(game_run), .restart(restart),
    .speed_level(speed_level), .xpos(xpos), .ypos(ypos), .enabled(enabled),
    .anim_frame(anim_frame), .step_pulse(step_pulse), .landed(landed)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int anim; int land;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: mode 0 = idle, 1 = marching, 2 = landed; dir +1 right, -1 left.
  int mx, my, mcnt, mdir, mmode, men, manim, mland;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int period_of(input int lvl);
    int p;
    p = 32 - 2 * lvl;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    mx = 32; my = 64; mcnt = 0; mdir = 1; mmode = 0; men = 0; manim = 0; mland = 0;
  endtask

  task automatic model_restart();
    mx = 32; my = 64; mcnt = 0; mdir = 1; mmode = 1; men = 1; manim = 0; mland = 0;
  endtask

  task automatic model_tick(input bit run, input int lvl);
    int nx;
    bit at_edge;
    exp_t e;
    if (!run || mmode == 2) return;
    if (mmode == 0) begin
      mmode = 1; mdir = 1; men = 1; mcnt = 0;
      return;
    end
    if (mcnt < period_of(lvl) - 1) begin
      mcnt++;
      return;
    end
    mcnt = 0;
    manim = 1 - manim;
    nx = mx + 8 * mdir;
    at_edge = (mdir > 0) ? (nx + 352 > 784) : (nx < 16);
    if (at_edge) begin
      if (my + 16 + 160 > 520) begin
        mmode = 2; mland = 1;
      end else begin
        my += 16; mdir = -mdir;
      end
    end else begin
      mx = nx;
    end
    e.x = mx; e.y = my; e.anim = manim; e.land = mland;
    sbq.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_xpos"}, xpos, mx);
    chk({tag, "_ypos"}, ypos, my);
    chk({tag, "_enabled"}, enabled, men);
    chk({tag, "_landed"}, landed, mland);
    chk({tag, "_anim"}, anim_frame, manim);
  endtask

  // One frame: vblnk high for 'hi' clocks then low for 2; restart may ride on the rising edge.
  task automatic do_frame(input bit run, input int lvl, input int hi, input bit rs);
    @(negedge clk);
    vblnk = 1'b1; game_run = run; speed_level = lvl[3:0]; restart = rs;
    if (rs) model_restart();
    else model_tick(run, lvl);
    @(negedge clk);
    restart = 1'b0;
    repeat (hi - 1) @(negedge clk);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int rand_hi();
    return ($urandom_range(0, 49) == 0) ? 10 : int'($urandom_range(1, 3));
  endfunction

  // Scoreboard monitor: every DUT step strobe consumes exactly one predicted step.
  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      if (sbq.size() == 0) begin
        chk("unexpected_step_pulse", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("step_xpos", xpos, mon_e.x);
        chk("step_ypos", ypos, mon_e.y);
        chk("step_anim", anim_frame, mon_e.anim);
        chk("step_landed", landed, mon_e.land);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    bit run;
    rst = 1'b1; vblnk = 1'b0; game_run = 1'b0; restart = 1'b0; speed_level = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset_step_pulse", step_pulse, 0);
    rst = 1'b0;

    do_frame(1'b0, 0, 1, 1'b0);
    check_outputs("idle_paused");
    do_frame(1'b1, 15, 1, 1'b0);
    check_outputs("start");

    // Mixed phase: pauses, speed changes (including mid-count), restarts.
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 9) != 0);
      lvl = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : 13 + int'($urandom_range(0, 2));
      do_frame(run, lvl, rand_hi(), $urandom_range(0, 99) == 0);
      check_outputs("mixed");
    end

    for (int i = 0; i < 8; i++) begin
      do_frame(1'b0, 15, rand_hi(), 1'b0);
      check_outputs("paused");
    end

    // Long march down to the landing line.
    for (int i = 0; i < 9000 && mland == 0; i++) begin
      run = ($urandom_range(0, 19) != 0);
      do_frame(run, 13 + int'($urandom_range(0, 2)), rand_hi(), 1'b0);
      check_outputs("march");
    end
    chk("landing_reached", landed, 1);
    for (int i = 0; i < 20; i++) begin
      do_frame(1'b1, 15, rand_hi(), 1'b0);
      check_outputs("frozen");
    end

    do_frame(1'b1, 15, 1, 1'b1);
    check_outputs("restart");
    for (int i = 0; i < 30; i++) begin
      do_frame(1'b1, 15, rand_hi(), 1'b0);
      check_outputs("post_restart");
    end

    // Reset landing on a tick cycle discards that tick entirely.
    @(negedge clk);
    vblnk = 1'b1; game_run = 1'b1; rst = 1'b1;
    model_reset();
    sbq.delete();
    @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    check_outputs("mid_reset");
    chk("mid_reset_step_pulse", step_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("after_reset");
    do_frame(1'b1, 15, 1, 1'b0);
    check_outputs("rerun");
    for (int i = 0; i < 6; i++) begin
      do_frame(1'b1, 15, rand_hi(), 1'b0);
      check_outputs("rerun_march");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
